// File: rtl/rf_black_widow_result_wb.sv
// Result writeback stage: per-source result FIFOs (ALU and load unit), an
// alternating arbiter onto the single register-file write port, a registered
// write/forwarding stage and a pending-write scoreboard query.
module rf_black_widow_result_wb #(
    parameter int WID   = 80,
    parameter int RW    = 6,
    parameter int DEPTH = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic           alu_v_i,
    input  logic [RW-1:0]  alu_rd_i,
    input  logic [WID-1:0] alu_res_i,
    output logic           alu_rdy_o,
    input  logic           mem_v_i,
    input  logic [RW-1:0]  mem_rd_i,
    input  logic [WID-1:0] mem_res_i,
    output logic           mem_rdy_o,
    output logic           wr_o,
    output logic [RW-1:0]  wr_rd_o,
    output logic [WID-1:0] wr_res_o,
    input  logic [RW-1:0]  q_rd_i,
    output logic           q_busy_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Last-grant state; MEM after reset so the ALU wins the first contention.
    localparam logic [0:0] GRANT_ALU = 1'b0;
    localparam logic [0:0] GRANT_MEM = 1'b1;

    // Source index 0 = ALU, 1 = MEM.
    logic [1:0]           src_v;
    logic [1:0]           src_full;
    logic [1:0]           src_ne;
    logic [1:0]           src_grant;
    logic [1:0]           src_busy;
    logic [1:0][RW-1:0]   src_rd;
    logic [1:0][WID-1:0]  src_res;
    logic [1:0][RW-1:0]   head_rd;
    logic [1:0][WID-1:0]  head_res;

    logic [0:0]           last_q, last_d;
    logic                 wr_q, wr_d;
    logic [RW-1:0]        wr_rd_q, wr_rd_d;
    logic [WID-1:0]       wr_res_q, wr_res_d;
    logic [RW-1:0]        sel_rd;
    logic [WID-1:0]       sel_res;

    assign src_v   = {mem_v_i, alu_v_i};
    assign src_rd  = {mem_rd_i, alu_rd_i};
    assign src_res = {mem_res_i, alu_res_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [RW-1:0]  rd_mem_q  [DEPTH];
            logic [WID-1:0] res_mem_q [DEPTH];
            logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
            logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]  count_q, count_d;
            logic           push;
            logic           pop;
            logic           hit;
            logic [PW-1:0]  offs;

            // Ready depends only on occupancy, so a full FIFO refuses even when popping.
            assign push = src_v[gi] & ~src_full[gi];
            assign pop  = src_grant[gi];

            // Pointer/occupancy next state; flush empties the FIFO and drops this cycle's push.
            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (flush_i) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
                    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
                    count_d = count_q + CW'(push) - CW'(pop);
                end
            end

            // Pointer and occupancy registers.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            // Entry storage; contents are only meaningful below the occupancy count.
            always_ff @(posedge clk_i) begin
                if (push) begin
                    rd_mem_q[wr_ptr_q]  <= src_rd[gi];
                    res_mem_q[wr_ptr_q] <= src_res[gi];
                end
            end

            // Scoreboard match over occupied slots (the head being popped still counts).
            always_comb begin
                hit  = 1'b0;
                offs = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    offs = PW'(i) - rd_ptr_q;
                    if ((CW'(offs) < count_q) && (rd_mem_q[i] == q_rd_i)) hit = 1'b1;
                end
            end

            assign src_busy[gi] = hit;
            assign src_ne[gi]   = (count_q != '0);
            assign src_full[gi] = (count_q == CW'(DEPTH));
            assign head_rd[gi]  = rd_mem_q[rd_ptr_q];
            assign head_res[gi] = res_mem_q[rd_ptr_q];
        end
    endgenerate

    // Alternating arbiter: a lone non-empty source wins, otherwise the one not granted last.
    always_comb begin
        src_grant = 2'b00;
        if (src_ne[0] && (!src_ne[1] || (last_q == GRANT_MEM))) src_grant[0] = 1'b1;
        else if (src_ne[1])                                     src_grant[1] = 1'b1;
    end

    assign sel_rd  = src_grant[1] ? head_rd[1]  : head_rd[0];
    assign sel_res = src_grant[1] ? head_res[1] : head_res[0];

    // Write-stage next state; r0 results retire silently, idle cycles hold tag/data.
    always_comb begin
        wr_d     = 1'b0;
        wr_rd_d  = wr_rd_q;
        wr_res_d = wr_res_q;
        last_d   = last_q;
        if (flush_i) begin
            last_d = GRANT_MEM;
        end else if (|src_grant) begin
            last_d = src_grant[1] ? GRANT_MEM : GRANT_ALU;
            if (sel_rd != '0) begin
                wr_d     = 1'b1;
                wr_rd_d  = sel_rd;
                wr_res_d = sel_res;
            end
        end
    end

    // Registered write port / forwarding bus and last-grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q     <= 1'b0;
            wr_rd_q  <= '0;
            wr_res_q <= '0;
            last_q   <= GRANT_MEM;
        end else begin
            wr_q     <= wr_d;
            wr_rd_q  <= wr_rd_d;
            wr_res_q <= wr_res_d;
            last_q   <= last_d;
        end
    end

    assign alu_rdy_o = ~src_full[0];
    assign mem_rdy_o = ~src_full[1];
    assign wr_o      = wr_q;
    assign wr_rd_o   = wr_rd_q;
    assign wr_res_o  = wr_res_q;
    assign q_busy_o  = (q_rd_i != '0) & (|src_busy);

endmodule

// File: tb/tb_rf_black_widow_result_wb.sv
// Directed bench for the result writeback stage.
module tb_rf_black_widow_result_wb;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        alu_v_i = 1'b0;
    logic [5:0]  alu_rd_i = '0;
    logic [79:0] alu_res_i = '0;
    logic        alu_rdy_o;
    logic        mem_v_i = 1'b0;
    logic [5:0]  mem_rd_i = '0;
    logic [79:0] mem_res_i = '0;
    logic        mem_rdy_o;
    logic        wr_o;
    logic [5:0]  wr_rd_o;
    logic [79:0] wr_res_o;
    logic [5:0]  q_rd_i = '0;
    logic        q_busy_o;

    int vectors = 0;
    int miscompares = 0;

    rf_black_widow_result_wb #(.WID(80), .RW(6), .DEPTH(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .alu_v_i(alu_v_i), .alu_rd_i(alu_rd_i), .alu_res_i(alu_res_i), .alu_rdy_o(alu_rdy_o),
        .mem_v_i(mem_v_i), .mem_rd_i(mem_rd_i), .mem_res_i(mem_res_i), .mem_rdy_o(mem_rdy_o),
        .wr_o(wr_o), .wr_rd_o(wr_rd_o), .wr_res_o(wr_res_o),
        .q_rd_i(q_rd_i), .q_busy_o(q_busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        alu_v_i = 1'b0; mem_v_i = 1'b0; flush_i = 1'b0;
        alu_rd_i = '0; mem_rd_i = '0; alu_res_i = '0; mem_res_i = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        vectors++; if (wr_o !== 1'b0) begin miscompares++; $display("FAIL reset_wr: got %b want 0", wr_o); end
        vectors++; if (wr_rd_o !== 6'd0) begin miscompares++; $display("FAIL reset_rd: got %0d want 0", wr_rd_o); end
        vectors++; if (wr_res_o !== 80'd0) begin miscompares++; $display("FAIL reset_res: got %h want 0", wr_res_o); end
        rst_ni = 1'b1;
        #1;
        vectors++; if ({alu_rdy_o, mem_rdy_o} !== 2'b11) begin miscompares++; $display("FAIL reset_rdy: got %b want 11", {alu_rdy_o, mem_rdy_o}); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        q_rd_i = 6'd5;
        alu_v_i = 1'b1; alu_rd_i = 6'd5; alu_res_i = 80'h1234;
        #1;
        vectors++; if (q_busy_o !== 1'b0) begin miscompares++; $display("FAIL single_busy_pre: got %b want 0", q_busy_o); end
        tick();
        alu_v_i = 1'b0;
        #1;
        vectors++; if (q_busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy_buf: got %b want 1", q_busy_o); end
        vectors++; if (wr_o !== 1'b0) begin miscompares++; $display("FAIL single_wr_e0: got %b want 0", wr_o); end
        tick();
        vectors++; if (wr_o !== 1'b1) begin miscompares++; $display("FAIL single_wr_e1: got %b want 1", wr_o); end
        vectors++; if (wr_rd_o !== 6'd5) begin miscompares++; $display("FAIL single_rd: got %0d want 5", wr_rd_o); end
        vectors++; if (wr_res_o !== 80'h1234) begin miscompares++; $display("FAIL single_res: got %h want 1234", wr_res_o); end
        vectors++; if (q_busy_o !== 1'b0) begin miscompares++; $display("FAIL single_busy_post: got %b want 0", q_busy_o); end
        tick();
        vectors++; if (wr_o !== 1'b0) begin miscompares++; $display("FAIL single_wr_e2: got %b want 0", wr_o); end
        vectors++; if (wr_rd_o !== 6'd5) begin miscompares++; $display("FAIL single_rd_hold: got %0d want 5", wr_rd_o); end
        q_rd_i = '0;
        $display("test_single done");
    endtask

    task automatic test_back_to_back();
        logic [85:0] qa[$];
        logic [85:0] qm[$];
        logic [85:0] exp;
        int nacc;
        int nwr;
        logic [5:0] na;
        logic [5:0] nm;
        nacc = 0; nwr = 0; na = 6'd1; nm = 6'd33;
        for (int k = 0; k < 16; k++) begin
            alu_v_i = (k < 8); mem_v_i = (k < 8);
            alu_rd_i = na; alu_res_i = {16'hAAAA, 58'h0, na};
            mem_rd_i = nm; mem_res_i = {16'hBBBB, 58'h0, nm};
            if (alu_v_i && alu_rdy_o) begin qa.push_back({alu_rd_i, alu_res_i}); na++; nacc++; end
            if (mem_v_i && mem_rdy_o) begin qm.push_back({mem_rd_i, mem_res_i}); nm++; nacc++; end
            tick();
            if (wr_o === 1'b1) begin
                if (nwr < 6) begin
                    vectors++;
                    if ((wr_rd_o >= 6'd32) !== (nwr % 2 == 1)) begin
                        miscompares++; $display("FAIL b2b_alternate: write %0d got rd %0d want source %s", nwr, wr_rd_o, (nwr % 2 == 1) ? "MEM" : "ALU");
                    end
                end
                vectors++;
                if (wr_rd_o >= 6'd32) begin
                    if (qm.size() == 0) begin miscompares++; $display("FAIL b2b_mem_extra: got rd %0d want none", wr_rd_o); end
                    else begin
                        exp = qm.pop_front();
                        if ({wr_rd_o, wr_res_o} !== exp) begin miscompares++; $display("FAIL b2b_mem_order: got %h want %h", {wr_rd_o, wr_res_o}, exp); end
                    end
                end else begin
                    if (qa.size() == 0) begin miscompares++; $display("FAIL b2b_alu_extra: got rd %0d want none", wr_rd_o); end
                    else begin
                        exp = qa.pop_front();
                        if ({wr_rd_o, wr_res_o} !== exp) begin miscompares++; $display("FAIL b2b_alu_order: got %h want %h", {wr_rd_o, wr_res_o}, exp); end
                    end
                end
                nwr++;
            end
        end
        idle_inputs();
        vectors++; if (nwr !== nacc) begin miscompares++; $display("FAIL b2b_count: got %0d writes want %0d", nwr, nacc); end
        vectors++; if (nwr < 6) begin miscompares++; $display("FAIL b2b_min_writes: got %0d want >=6", nwr); end
        $display("test_back_to_back done: %0d writes", nwr);
    endtask

    task automatic test_rd_zero();
        q_rd_i = 6'd0;
        alu_v_i = 1'b1; alu_rd_i = 6'd0; alu_res_i = 80'hFF;
        tick();
        vectors++; if (q_busy_o !== 1'b0) begin miscompares++; $display("FAIL rd0_busy: got %b want 0", q_busy_o); end
        vectors++; if (wr_o !== 1'b0) begin miscompares++; $display("FAIL rd0_wr_e0: got %b want 0", wr_o); end
        alu_rd_i = 6'd7; alu_res_i = 80'h77;
        mem_v_i = 1'b1; mem_rd_i = 6'd50; mem_res_i = 80'h5050;
        tick();
        idle_inputs();
        vectors++; if (wr_o !== 1'b0) begin miscompares++; $display("FAIL rd0_wr_e1: got %b want 0", wr_o); end
        vectors++; if (wr_rd_o !== 6'd0) begin miscompares++; $display("FAIL rd0_rd_hold: got %0d want 0", wr_rd_o); end
        tick();
        vectors++; if ({wr_o, wr_rd_o} !== {1'b1, 6'd50}) begin miscompares++; $display("FAIL rd0_next_mem: got wr=%b rd=%0d want wr=1 rd=50", wr_o, wr_rd_o); end
        tick();
        vectors++; if ({wr_o, wr_rd_o} !== {1'b1, 6'd7}) begin miscompares++; $display("FAIL rd0_next_alu: got wr=%b rd=%0d want wr=1 rd=7", wr_o, wr_rd_o); end
        tick();
        vectors++; if (wr_o !== 1'b0) begin miscompares++; $display("FAIL rd0_idle: got %b want 0", wr_o); end
        $display("test_rd_zero done");
    endtask

    task automatic test_full();
        int t_av  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
        int t_ard [8] = '{10, 11, 12, 13, 13, 0, 0, 0};
        int t_mv  [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
        int t_mrd [8] = '{40, 41, 0, 0, 0, 0, 0, 0};
        int e_wr  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        int e_rd  [8] = '{0, 10, 40, 11, 41, 12, 13, 13};
        int e_ardy[8] = '{1, 1, 0, 1, 0, 1, 1, 1};
        for (int k = 0; k < 8; k++) begin
            alu_v_i = (t_av[k] != 0); alu_rd_i = 6'(t_ard[k]); alu_res_i = 80'(t_ard[k]);
            mem_v_i = (t_mv[k] != 0); mem_rd_i = 6'(t_mrd[k]); mem_res_i = 80'(t_mrd[k]);
            tick();
            vectors++;
            if ({wr_o, wr_rd_o, wr_res_o, alu_rdy_o} !== {e_wr[k] != 0, 6'(e_rd[k]), 80'(e_rd[k]), e_ardy[k] != 0}) begin
                miscompares++;
                $display("FAIL full_cycle%0d: got wr=%b rd=%0d res=%h ardy=%b want wr=%0d rd=%0d res=%h ardy=%0d",
                         k, wr_o, wr_rd_o, wr_res_o, alu_rdy_o, e_wr[k], e_rd[k], 80'(e_rd[k]), e_ardy[k]);
            end
        end
        idle_inputs();
        $display("test_full done");
    endtask

    task automatic test_flush();
        alu_v_i = 1'b1; alu_rd_i = 6'd21; alu_res_i = 80'd21;
        mem_v_i = 1'b1; mem_rd_i = 6'd51; mem_res_i = 80'd51;
        tick();
        alu_rd_i = 6'd22; alu_res_i = 80'd22; mem_rd_i = 6'd52; mem_res_i = 80'd52;
        tick();
        alu_rd_i = 6'd23; alu_res_i = 80'd23; mem_rd_i = 6'd53; mem_res_i = 80'd53;
        tick();
        vectors++; if ({wr_o, wr_rd_o} !== {1'b1, 6'd51}) begin miscompares++; $display("FAIL flush_prewrite: got wr=%b rd=%0d want wr=1 rd=51", wr_o, wr_rd_o); end
        flush_i = 1'b1;
        alu_rd_i = 6'd29; alu_res_i = 80'd29; mem_rd_i = 6'd59; mem_res_i = 80'd59;
        q_rd_i = 6'd23;
        #1;
        vectors++; if (q_busy_o !== 1'b1) begin miscompares++; $display("FAIL flush_busy_pre: got %b want 1", q_busy_o); end
        vectors++; if ({alu_rdy_o, mem_rdy_o} !== 2'b01) begin miscompares++; $display("FAIL flush_rdy_pre: got %b want 01", {alu_rdy_o, mem_rdy_o}); end
        tick();
        idle_inputs();
        #1;
        vectors++; if (wr_o !== 1'b0) begin miscompares++; $display("FAIL flush_wr: got %b want 0", wr_o); end
        vectors++; if (wr_rd_o !== 6'd51) begin miscompares++; $display("FAIL flush_rd_hold: got %0d want 51", wr_rd_o); end
        vectors++; if ({alu_rdy_o, mem_rdy_o} !== 2'b11) begin miscompares++; $display("FAIL flush_rdy_post: got %b want 11", {alu_rdy_o, mem_rdy_o}); end
        vectors++; if (q_busy_o !== 1'b0) begin miscompares++; $display("FAIL flush_busy_23: got %b want 0", q_busy_o); end
        q_rd_i = 6'd29;
        #1;
        vectors++; if (q_busy_o !== 1'b0) begin miscompares++; $display("FAIL flush_busy_29: got %b want 0", q_busy_o); end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (wr_o !== 1'b0) begin miscompares++; $display("FAIL flush_drained%0d: got wr=%b rd=%0d want wr=0", k, wr_o, wr_rd_o); end
        end
        q_rd_i = '0;
        alu_v_i = 1'b1; alu_rd_i = 6'd30; alu_res_i = 80'd30;
        mem_v_i = 1'b1; mem_rd_i = 6'd60; mem_res_i = 80'd60;
        tick();
        idle_inputs();
        tick();
        vectors++; if ({wr_o, wr_rd_o} !== {1'b1, 6'd30}) begin miscompares++; $display("FAIL flush_after_alu: got wr=%b rd=%0d want wr=1 rd=30", wr_o, wr_rd_o); end
        tick();
        vectors++; if ({wr_o, wr_rd_o} !== {1'b1, 6'd60}) begin miscompares++; $display("FAIL flush_after_mem: got wr=%b rd=%0d want wr=1 rd=60", wr_o, wr_rd_o); end
        tick();
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            alu_v_i = 1'b1; alu_rd_i = 6'(1 + k); alu_res_i = 80'(1 + k);
            mem_v_i = 1'b1; mem_rd_i = 6'(33 + k); mem_res_i = 80'(33 + k);
            tick();
        end
        idle_inputs();
        vectors++; if (wr_o !== 1'b1) begin miscompares++; $display("FAIL arst_pre_wr: got %b want 1", wr_o); end
        q_rd_i = 6'd3;
        #2;
        rst_ni = 1'b0;
        #1;
        vectors++; if ({wr_o, wr_rd_o, wr_res_o} !== {1'b0, 6'd0, 80'd0}) begin miscompares++; $display("FAIL arst_outputs: got wr=%b rd=%0d res=%h want all 0", wr_o, wr_rd_o, wr_res_o); end
        vectors++; if ({alu_rdy_o, mem_rdy_o, q_busy_o} !== 3'b110) begin miscompares++; $display("FAIL arst_rdy_busy: got %b want 110", {alu_rdy_o, mem_rdy_o, q_busy_o}); end
        #2;
        rst_ni = 1'b1;
        q_rd_i = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (wr_o !== 1'b0) begin miscompares++; $display("FAIL arst_idle%0d: got wr=%b rd=%0d want wr=0", k, wr_o, wr_rd_o); end
        end
        alu_v_i = 1'b1; alu_rd_i = 6'd9; alu_res_i = 80'h99;
        tick();
        idle_inputs();
        tick();
        vectors++; if ({wr_o, wr_rd_o, wr_res_o} !== {1'b1, 6'd9, 80'h99}) begin miscompares++; $display("FAIL arst_new_push: got wr=%b rd=%0d res=%h want wr=1 rd=9 res=99", wr_o, wr_rd_o, wr_res_o); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_single();
        apply_reset();
        test_back_to_back();
        apply_reset();
        test_rd_zero();
        apply_reset();
        test_full();
        apply_reset();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
